issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of two, >= 4.
REQ-002 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-003 SHALL have clock_i, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have reset_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have flush_i, input, 1, synchronous queue clear.
REQ-006 SHALL have enq_valid0_i/enq_valid1_i, input, 1 each, decode lane valids; lane 0 is older.
REQ-007 SHALL have enq_inst0_i/enq_inst1_i, input, 32 each, instruction words.
REQ-008 SHALL have enq_ctrl0_i/enq_ctrl1_i, input, `CTRL_BUS each, control bundles.
REQ-009 SHALL have enq_pred0_i/enq_pred1_i, input, 1 each, and enq_pred_tgt0_i/enq_pred_tgt1_i, input, 32 each, branch prediction and target.
REQ-010 SHALL have enq_ready_o, output, 1, registered; high when at least two entries are free.
REQ-011 SHALL have stall_i, input, 1, downstream stall; no dequeue while high.
REQ-012 SHALL have iss_valid0_o/iss_valid1_o, output, 1 each, and matching iss_inst*_o (32), iss_ctrl*_o (`CTRL_BUS), iss_pred*_o (1), iss_pred_tgt*_o (32).
REQ-013 SHALL have iss_older_lane_o, output, 1, lane holding the older issued instruction.
REQ-014 SHALL have count_o, output, $clog2(DEPTH)+1, occupancy.
REQ-015 SHALL have dual_cnt_o and single_cnt_o, output, CNT_W each, issue statistics.

Function
REQ-016 SHALL store entries {inst, ctrl, pred, pred_tgt} in a circular buffer with head/tail pointers wrapping modulo DEPTH.
REQ-017 SHALL write accepted instructions compacted in age order: lane 0 then lane 1; lone enq_valid1_i writes one entry.
REQ-018 SHALL accept enqueue only when enq_ready_o is high; enqueue attempts while it is low are ignored, with no state change.
REQ-019 SHALL compute enq_ready_o from registered count (count <= DEPTH-2); it does not depend on same-cycle dequeue.
REQ-020 SHALL give a minimum enqueue-to-issue latency of one cycle; no same-cycle bypass.
REQ-021 SHALL present issue combinationally from head entries O (older) and Y (younger, valid when count >= 2).
REQ-022 SHALL flag dep when O has REGWRITE set, O.rd is nonzero, and Y reads it through RS1 or RS2 with the matching ACTIVE bit set.
REQ-023 SHALL flag slot_conflict when O and Y both have ISSUE_PRI set and their ISSUE_SLOT values are equal.
REQ-024 SHALL dual-issue when count >= 2, !dep, and !slot_conflict; otherwise it single-issues O when count >= 1.
REQ-025 SHALL steer lanes as follows:
- O.ISSUE_PRI set: O goes to lane O.ISSUE_SLOT and Y to the other lane.
- Else Y.ISSUE_PRI set: Y goes to lane Y.ISSUE_SLOT and O to the other lane.
- Else: O goes to lane 0 and Y to lane 1.
- Single issue: O goes to O.ISSUE_SLOT if O.ISSUE_PRI is set, else lane 0; the other lane's valid is 0.
REQ-026 SHALL drive iss_older_lane_o to the lane holding O; it is 0 when nothing issues.
REQ-027 SHALL advance head by the issued count when !stall_i; simultaneous enqueue and dequeue update count by their net difference.
REQ-028 SHALL hold iss_* outputs stable while stall_i is high.
REQ-029 SHALL give flush_i priority over same-cycle enqueue and dequeue: head, tail, and count go to 0 at the next edge.
REQ-030 SHALL keep all iss_valid*_o at 0 when count is 0.

Reset
REQ-031 SHALL, on reset_n_i low, asynchronously clear head, tail, count, and statistics counters.
REQ-032 SHALL hold enq_ready_o at 1 and all iss_valid*_o at 0 from reset; entry storage is not reset.
REQ-033 SHALL lose all contents when reset asserts mid-operation; no partial issue follows release.

Configuration
REQ-034 SHALL, with ISSUEQ_STATS_EN defined, increment dual_cnt_o on each dual issue and single_cnt_o on each single issue, counting only when !stall_i and !flush_i; counters saturate at all-ones.
REQ-035 SHALL, without ISSUEQ_STATS_EN, tie dual_cnt_o and single_cnt_o to 0 and instantiate no counter logic.

Structure
REQ-036 SHALL place the CTRL_BUS field indices, the ISSUE_PRI/ISSUE_SLOT encodings, and the RAW-check function in the shared defs header.
REQ-037 SHALL implement steering (REQ-022..026) in one combinational sub-module, issue_steer; storage and pointers remain in issue_queue.

Verification
REQ-038 SHALL cover independent pair: enqueue addi x1 then addi x2 (no PRI); next cycle iss_valid0/1 = 1/1, iss_older_lane_o = 0, count goes 2 -> 0.
REQ-039 SHALL cover RAW: enqueue addi x5,x0,1 then add x6,x5,x5; cycle 1 issues only the addi on lane 0; cycle 2 issues the add on lane 0.
REQ-040 SHALL cover steering: O with PRI slot 1 plus a plain Y; Y goes to lane 0, O to lane 1, iss_older_lane_o = 1. O and Y both PRI slot 0 issue in two cycles.
REQ-041 SHALL cover fill and wrap: DEPTH=8, stall_i=1, enqueue four pairs; enq_ready_o falls when count reaches 8. Releasing stall drains in 4 cycles; refill then wraps tail to index 0 with data intact.
REQ-042 SHALL cover flush and reset: count 6 with flush_i plus simultaneous enqueue gives count 0 next cycle. Asserting reset_n_i mid-drain clears count and valids immediately without a clock edge.
REQ-043 SHALL cover stats: with ISSUEQ_STATS_EN, 3 dual issues plus 2 single issues give dual_cnt_o = 3 and single_cnt_o = 2; without the macro both read 0.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared definitions for the dual-issue queue: control-bus field layout, entry format
// and the read-after-write check used by the steering logic.
package issue_queue_pkg;

  localparam int CTRL_BUS = 5;

  // Control-bus bit positions
  localparam int CTRL_REGWRITE   = 0;
  localparam int CTRL_RS1_ACTIVE = 1;
  localparam int CTRL_RS2_ACTIVE = 2;
  localparam int CTRL_ISSUE_PRI  = 3;
  localparam int CTRL_ISSUE_SLOT = 4;

  // ISSUE_SLOT encodings double as lane numbers
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef struct packed {
    logic [31:0]         inst;
    logic [CTRL_BUS-1:0] ctrl;
    logic                pred;
    logic [31:0]         pred_tgt;
  } iq_entry_t;

  // True when the younger entry reads a register the older one writes
  function automatic logic raw_dep(input iq_entry_t o, input iq_entry_t y);
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    rd  = o.inst[11:7];
    rs1 = y.inst[19:15];
    rs2 = y.inst[24:20];
    return o.ctrl[CTRL_REGWRITE] && (rd != 5'd0) &&
           ((y.ctrl[CTRL_RS1_ACTIVE] && (rs1 == rd)) ||
            (y.ctrl[CTRL_RS2_ACTIVE] && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Decode-side enqueue, issue-side dequeue and status bundle of the issue queue.
// master = decoder/environment, slave = the queue itself.
interface issue_queue_if
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
);
  localparam int COUNT_W = $clog2(DEPTH) + 1;

  logic                flush_i;
  logic                stall_i;
  logic                enq_valid0_i, enq_valid1_i;
  logic [31:0]         enq_inst0_i, enq_inst1_i;
  logic [CTRL_BUS-1:0] enq_ctrl0_i, enq_ctrl1_i;
  logic                enq_pred0_i, enq_pred1_i;
  logic [31:0]         enq_pred_tgt0_i, enq_pred_tgt1_i;
  logic                enq_ready_o;
  logic                iss_valid0_o, iss_valid1_o;
  logic [31:0]         iss_inst0_o, iss_inst1_o;
  logic [CTRL_BUS-1:0] iss_ctrl0_o, iss_ctrl1_o;
  logic                iss_pred0_o, iss_pred1_o;
  logic [31:0]         iss_pred_tgt0_o, iss_pred_tgt1_o;
  logic                iss_older_lane_o;
  logic [COUNT_W-1:0]  count_o;
  logic [CNT_W-1:0]    dual_cnt_o, single_cnt_o;

  modport master (
    output flush_i, stall_i, enq_valid0_i, enq_valid1_i, enq_inst0_i, enq_inst1_i,
           enq_ctrl0_i, enq_ctrl1_i, enq_pred0_i, enq_pred1_i, enq_pred_tgt0_i, enq_pred_tgt1_i,
    input  enq_ready_o, iss_valid0_o, iss_valid1_o, iss_inst0_o, iss_inst1_o,
           iss_ctrl0_o, iss_ctrl1_o, iss_pred0_o, iss_pred1_o, iss_pred_tgt0_o, iss_pred_tgt1_o,
           iss_older_lane_o, count_o, dual_cnt_o, single_cnt_o
  );

  modport slave (
    input  flush_i, stall_i, enq_valid0_i, enq_valid1_i, enq_inst0_i, enq_inst1_i,
           enq_ctrl0_i, enq_ctrl1_i, enq_pred0_i, enq_pred1_i, enq_pred_tgt0_i, enq_pred_tgt1_i,
    output enq_ready_o, iss_valid0_o, iss_valid1_o, iss_inst0_o, iss_inst1_o,
           iss_ctrl0_o, iss_ctrl1_o, iss_pred0_o, iss_pred1_o, iss_pred_tgt0_o, iss_pred_tgt1_o,
           iss_older_lane_o, count_o, dual_cnt_o, single_cnt_o
  );
endinterface

// File: rtl/issue_steer.sv
// Pairing and lane-steering decision for the two oldest queue entries (O older, Y younger).
// Purely combinational; the queue routes entry data using older_lane.
module issue_steer
  import issue_queue_pkg::*;
(
  input  iq_entry_t o_ent,
  input  iq_entry_t y_ent,
  input  logic      have_one,
  input  logic      have_two,
  output logic      valid0,
  output logic      valid1,
  output logic      older_lane
);
  logic o_pri, y_pri, o_slot, y_slot;
  logic dep, slot_conflict, dual;

  assign o_pri  = o_ent.ctrl[CTRL_ISSUE_PRI];
  assign y_pri  = y_ent.ctrl[CTRL_ISSUE_PRI];
  assign o_slot = o_ent.ctrl[CTRL_ISSUE_SLOT];
  assign y_slot = y_ent.ctrl[CTRL_ISSUE_SLOT];

  assign dep           = raw_dep(o_ent, y_ent);
  assign slot_conflict = o_pri && y_pri && (o_slot == y_slot);
  assign dual          = have_two && !dep && !slot_conflict;

  always_comb begin
    // NOTE: defaults on every output up front so no path leaves one unassigned (no latch).
    valid0     = 1'b0;
    valid1     = 1'b0;
    older_lane = LANE0;
    if (dual) begin
      valid0 = 1'b1;
      valid1 = 1'b1;
      if (o_pri)      older_lane = o_slot;
      else if (y_pri) older_lane = ~y_slot;
    end else if (have_one) begin
      older_lane = o_pri ? o_slot : LANE0;
      valid0     = (older_lane == LANE0);
      valid1     = (older_lane == LANE1);
    end
  end
endmodule

// File: rtl/issue_queue.sv
// Dual-enqueue / dual-issue circular instruction queue with RAW and slot-aware steering.
// Optional saturating issue statistics are built when ISSUEQ_STATS_EN is defined.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
)(
  input  logic          clock_i,
  input  logic          reset_n_i,
  issue_queue_if.slave  iq
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  iq_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q, head_p1, tail_p1;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               enq_ready_q;
  logic               stall_q, hold_valid_q, hold_v0_q, hold_v1_q, hold_lane_q;

  iq_entry_t enq0, enq1, o_ent, y_ent, lane0, lane1;
  logic      enq_fire, held;
  logic      st_v0, st_v1, st_lane;
  logic      iss_v0, iss_v1, iss_lane;
  logic [1:0] n_enq, n_deq;

  assign enq0 = '{inst: iq.enq_inst0_i, ctrl: iq.enq_ctrl0_i, pred: iq.enq_pred0_i,
                  pred_tgt: iq.enq_pred_tgt0_i};
  assign enq1 = '{inst: iq.enq_inst1_i, ctrl: iq.enq_ctrl1_i, pred: iq.enq_pred1_i,
                  pred_tgt: iq.enq_pred_tgt1_i};

  assign head_p1  = head_q + PTR_W'(1);
  assign tail_p1  = tail_q + PTR_W'(1);
  assign enq_fire = enq_ready_q && !iq.flush_i;
  assign n_enq    = enq_fire ? ({1'b0, iq.enq_valid0_i} + {1'b0, iq.enq_valid1_i}) : 2'd0;

  // NOTE: entry storage carries no reset; occupancy alone says which entries are live.
  always_ff @(posedge clock_i) begin
    if (enq_fire) begin
      if (iq.enq_valid0_i) mem[tail_q] <= enq0;
      if (iq.enq_valid1_i) mem[iq.enq_valid0_i ? tail_p1 : tail_q] <= enq1;
    end
  end

  assign o_ent = mem[head_q];
  assign y_ent = mem[head_p1];

  issue_steer u_steer (
    .o_ent      (o_ent),
    .y_ent      (y_ent),
    .have_one   (count_q != '0),
    .have_two   (count_q >= COUNT_W'(2)),
    .valid0     (st_v0),
    .valid1     (st_v1),
    .older_lane (st_lane)
  );

  // Once a stalled decision is on the outputs, freeze it until the stall lifts
  assign held     = iq.stall_i && stall_q && hold_valid_q;
  assign iss_v0   = held ? hold_v0_q   : st_v0;
  assign iss_v1   = held ? hold_v1_q   : st_v1;
  assign iss_lane = held ? hold_lane_q : st_lane;

  assign lane0 = iss_lane ? y_ent : o_ent;
  assign lane1 = iss_lane ? o_ent : y_ent;

  assign n_deq   = iq.stall_i ? 2'd0 : ({1'b0, iss_v0} + {1'b0, iss_v1});
  assign count_d = count_q + COUNT_W'(n_enq) - COUNT_W'(n_deq);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      enq_ready_q  <= 1'b1;
      stall_q      <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_v0_q    <= 1'b0;
      hold_v1_q    <= 1'b0;
      hold_lane_q  <= 1'b0;
    end else if (iq.flush_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      enq_ready_q  <= 1'b1;
      stall_q      <= 1'b0;
      hold_valid_q <= 1'b0;
    end else begin
      head_q       <= head_q + PTR_W'(n_deq);
      tail_q       <= tail_q + PTR_W'(n_enq);
      count_q      <= count_d;
      enq_ready_q  <= (count_d <= COUNT_W'(DEPTH - 2));
      stall_q      <= iq.stall_i;
      hold_valid_q <= iss_v0 || iss_v1;
      hold_v0_q    <= iss_v0;
      hold_v1_q    <= iss_v1;
      hold_lane_q  <= iss_lane;
    end
  end

  assign iq.enq_ready_o      = enq_ready_q;
  assign iq.count_o          = count_q;
  assign iq.iss_valid0_o     = iss_v0;
  assign iq.iss_valid1_o     = iss_v1;
  assign iq.iss_older_lane_o = iss_lane;
  assign iq.iss_inst0_o      = lane0.inst;
  assign iq.iss_inst1_o      = lane1.inst;
  assign iq.iss_ctrl0_o      = lane0.ctrl;
  assign iq.iss_ctrl1_o      = lane1.ctrl;
  assign iq.iss_pred0_o      = lane0.pred;
  assign iq.iss_pred1_o      = lane1.pred;
  assign iq.iss_pred_tgt0_o  = lane0.pred_tgt;
  assign iq.iss_pred_tgt1_o  = lane1.pred_tgt;

`ifdef ISSUEQ_STATS_EN
  logic             dual_issue, single_issue;
  logic [CNT_W-1:0] dual_cnt_q, single_cnt_q;

  assign dual_issue   = iss_v0 && iss_v1;
  assign single_issue = iss_v0 ^ iss_v1;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dual_cnt_q   <= '0;
      single_cnt_q <= '0;
    end else if (!iq.stall_i && !iq.flush_i) begin
      if (dual_issue && !(&dual_cnt_q))     dual_cnt_q   <= dual_cnt_q + CNT_W'(1);
      if (single_issue && !(&single_cnt_q)) single_cnt_q <= single_cnt_q + CNT_W'(1);
    end
  end

  assign iq.dual_cnt_o   = dual_cnt_q;
  assign iq.single_cnt_o = single_cnt_q;
`else
  assign iq.dual_cnt_o   = '0;
  assign iq.single_cnt_o = '0;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: directed enqueue sequences push expected issue
// records; a negedge monitor pops and compares whenever the queue issues.
module tb_issue_queue;
  localparam logic [4:0] C_ADDI = 5'b00011;
  localparam logic [4:0] C_ADD  = 5'b00111;
  localparam logic [4:0] C_PRI0 = 5'b01000;
  localparam logic [4:0] C_PRI1 = 5'b11000;

  typedef struct {
    bit          v0, v1, older;
    logic [31:0] i0, i1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  issue_queue_if #(.DEPTH(8), .CNT_W(32)) bus ();

  issue_queue #(.DEPTH(8), .CNT_W(32)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .iq        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
  endfunction

  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] inst);
    return inst + 32'h0000_1000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_iss(input bit v0, input bit v1, input bit older,
                            input logic [31:0] i0, input logic [31:0] i1);
    exp_t e;
    e.v0 = v0; e.v1 = v1; e.older = older; e.i0 = i0; e.i1 = i1;
    exp_q.push_back(e);
  endtask

  task automatic enq(input bit v0, input logic [31:0] i0, input logic [4:0] c0,
                     input bit v1, input logic [31:0] i1, input logic [4:0] c1);
    bus.enq_valid0_i = v0; bus.enq_inst0_i = i0; bus.enq_ctrl0_i = c0;
    bus.enq_pred0_i = i0[7]; bus.enq_pred_tgt0_i = tgt_of(i0);
    bus.enq_valid1_i = v1; bus.enq_inst1_i = i1; bus.enq_ctrl1_i = c1;
    bus.enq_pred1_i = i1[7]; bus.enq_pred_tgt1_i = tgt_of(i1);
    cyc();
    bus.enq_valid0_i = 1'b0;
    bus.enq_valid1_i = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    for (int i = 0; i < budget && (bus.count_o != 0 || exp_q.size() != 0); i++) cyc();
    check({"drained ", name}, (bus.count_o == 0) && (exp_q.size() == 0), 1);
    check({"idle valids ", name}, {bus.iss_valid0_o, bus.iss_valid1_o}, 0);
  endtask

  // Monitor: every non-stalled issue must match the oldest pending expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !bus.stall_i && (bus.iss_valid0_o || bus.iss_valid1_o)) begin
        check("issue expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("iss_valid0", bus.iss_valid0_o, e.v0);
          check("iss_valid1", bus.iss_valid1_o, e.v1);
          check("iss_older_lane", bus.iss_older_lane_o, e.older);
          if (e.v0) begin
            check("iss_inst0", bus.iss_inst0_o, e.i0);
            check("iss_pred_tgt0", bus.iss_pred_tgt0_o, tgt_of(e.i0));
          end
          if (e.v1) begin
            check("iss_inst1", bus.iss_inst1_o, e.i1);
            check("iss_pred_tgt1", bus.iss_pred_tgt1_o, tgt_of(e.i1));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bus.flush_i = 1'b0; bus.stall_i = 1'b0;
    bus.enq_valid0_i = 1'b0; bus.enq_valid1_i = 1'b0;
    bus.enq_inst0_i = '0; bus.enq_inst1_i = '0;
    bus.enq_ctrl0_i = '0; bus.enq_ctrl1_i = '0;
    bus.enq_pred0_i = 1'b0; bus.enq_pred1_i = 1'b0;
    bus.enq_pred_tgt0_i = '0; bus.enq_pred_tgt1_i = '0;

    #12;
    check("reset count", bus.count_o, 0);
    check("reset enq_ready", bus.enq_ready_o, 1);
    check("reset valids", {bus.iss_valid0_o, bus.iss_valid1_o}, 0);
    check("reset dual_cnt", bus.dual_cnt_o, 0);
    check("reset single_cnt", bus.single_cnt_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc();

    // Independent pair: dual issue in natural order, count 2 -> 0
    expect_iss(1, 1, 0, addi(1, 0, 1), addi(2, 0, 2));
    enq(1, addi(1, 0, 1), C_ADDI, 1, addi(2, 0, 2), C_ADDI);
    check("pair count after enq", bus.count_o, 2);
    cyc();
    check("pair count after issue", bus.count_o, 0);
    wait_empty("pair", 10);

    // RAW: add reads x5 written by the older addi -> two single issues on lane 0
    expect_iss(1, 0, 0, addi(5, 0, 1), 0);
    expect_iss(1, 0, 0, add(6, 5, 5), 0);
    enq(1, addi(5, 0, 1), C_ADDI, 1, add(6, 5, 5), C_ADD);
    cyc();
    check("raw count after first issue", bus.count_o, 1);
    wait_empty("raw", 10);

    // Steering: O pinned to slot 1 -> Y on lane 0, older lane 1
    expect_iss(1, 1, 1, addi(4, 0, 4), addi(3, 0, 3));
    enq(1, addi(3, 0, 3), C_ADDI | C_PRI1, 1, addi(4, 0, 4), C_ADDI);
    wait_empty("o pri slot1", 10);
    // Both pinned to slot 0 -> conflict, two singles
    expect_iss(1, 0, 0, addi(7, 0, 7), 0);
    expect_iss(1, 0, 0, addi(8, 0, 8), 0);
    enq(1, addi(7, 0, 7), C_ADDI | C_PRI0, 1, addi(8, 0, 8), C_ADDI | C_PRI0);
    wait_empty("slot conflict", 10);
    // Only Y pinned to slot 0 -> O on lane 1
    expect_iss(1, 1, 1, addi(10, 0, 10), addi(9, 0, 9));
    enq(1, addi(9, 0, 9), C_ADDI, 1, addi(10, 0, 10), C_ADDI | C_PRI0);
    wait_empty("y pri slot0", 10);
    // Lone lane-1 enqueue pinned to slot 1 -> single on lane 1
    expect_iss(0, 1, 1, 0, addi(11, 0, 11));
    enq(0, 0, 0, 1, addi(11, 0, 11), C_ADDI | C_PRI1);
    check("lone lane1 count", bus.count_o, 1);
    wait_empty("lone lane1", 10);

    // Fill under stall, overfill attempt ignored, drain in 4 cycles, refill across wrap
    bus.stall_i = 1'b1;
    for (int p = 0; p < 4; p++) begin
      expect_iss(1, 1, 0, addi(12 + 2 * p, 0, p), addi(13 + 2 * p, 0, p));
      enq(1, addi(12 + 2 * p, 0, p), C_ADDI, 1, addi(13 + 2 * p, 0, p), C_ADDI);
      if (p == 2) check("enq_ready at count 6", bus.enq_ready_o, 1);
    end
    check("full count", bus.count_o, 8);
    check("full enq_ready", bus.enq_ready_o, 0);
    check("stalled held inst0", bus.iss_inst0_o, addi(12, 0, 0));
    check("stalled held valid1", bus.iss_valid1_o, 1);
    enq(1, addi(30, 0, 30), C_ADDI, 1, addi(31, 0, 31), C_ADDI);
    check("overfill ignored", bus.count_o, 8);
    bus.stall_i = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      cyc();
      check("drain count", bus.count_o, 2 * k);
    end
    check("enq_ready after drain", bus.enq_ready_o, 1);
    expect_iss(1, 1, 0, addi(20, 0, 100), addi(21, 0, 101));
    expect_iss(1, 1, 0, addi(22, 0, 102), addi(23, 0, 103));
    enq(1, addi(20, 0, 100), C_ADDI, 1, addi(21, 0, 101), C_ADDI);
    enq(1, addi(22, 0, 102), C_ADDI, 1, addi(23, 0, 103), C_ADDI);
    wait_empty("refill", 10);

    // Flush at count 6 beats a simultaneous enqueue
    bus.stall_i = 1'b1;
    for (int p = 0; p < 3; p++) enq(1, addi(24, 0, p), C_ADDI, 1, addi(25, 0, p), C_ADDI);
    check("pre-flush count", bus.count_o, 6);
    bus.flush_i = 1'b1;
    enq(1, addi(26, 0, 1), C_ADDI, 1, addi(27, 0, 1), C_ADDI);
    bus.flush_i = 1'b0;
    check("flush count", bus.count_o, 0);
    check("flush valids", {bus.iss_valid0_o, bus.iss_valid1_o}, 0);
    check("flush enq_ready", bus.enq_ready_o, 1);
    bus.stall_i = 1'b0;
    cyc();
    check("post-flush count", bus.count_o, 0);

    // Reset mid-drain clears state without a clock edge
    bus.stall_i = 1'b1;
    expect_iss(1, 1, 0, addi(1, 0, 50), addi(2, 0, 51));
    expect_iss(1, 1, 0, addi(3, 0, 52), addi(4, 0, 53));
    enq(1, addi(1, 0, 50), C_ADDI, 1, addi(2, 0, 51), C_ADDI);
    enq(1, addi(3, 0, 52), C_ADDI, 1, addi(4, 0, 53), C_ADDI);
    bus.stall_i = 1'b0;
    cyc();
    check("mid-drain count", bus.count_o, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async reset count", bus.count_o, 0);
    check("async reset valids", {bus.iss_valid0_o, bus.iss_valid1_o}, 0);
    check("async reset enq_ready", bus.enq_ready_o, 1);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    cyc();
    check("post-reset count", bus.count_o, 0);
    check("post-reset valids", {bus.iss_valid0_o, bus.iss_valid1_o}, 0);
    check("post-reset dual_cnt", bus.dual_cnt_o, 0);

    // Statistics: three dual issues then two single issues
    for (int p = 0; p < 3; p++) begin
      expect_iss(1, 1, 0, addi(1, 0, 60 + p), addi(2, 0, 70 + p));
      enq(1, addi(1, 0, 60 + p), C_ADDI, 1, addi(2, 0, 70 + p), C_ADDI);
      wait_empty("stats dual", 10);
    end
    expect_iss(1, 0, 0, addi(3, 0, 80), 0);
    enq(1, addi(3, 0, 80), C_ADDI, 0, 0, 0);
    wait_empty("stats single a", 10);
    expect_iss(1, 0, 0, addi(4, 0, 81), 0);
    enq(0, 0, 0, 1, addi(4, 0, 81), C_ADDI);
    wait_empty("stats single b", 10);
`ifdef ISSUEQ_STATS_EN
    check("dual_cnt", bus.dual_cnt_o, 3);
    check("single_cnt", bus.single_cnt_o, 2);
`else
    check("dual_cnt tied off", bus.dual_cnt_o, 0);
    check("single_cnt tied off", bus.single_cnt_o, 0);
`endif

    cyc();
    check("scoreboard empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
